// File: rtl/atm_session_initiator.sv
// atm_session_initiator: keypad front end collecting account/PIN/menu/amount and issuing requests to the account core.
// Define ATM_LOCKOUT_EN to build the LOCKED state entered after MAX_TRIES consecutive AUTH failures.
module atm_session_initiator #(
   parameter int AMT_DIGITS  = 5,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int MAX_TRIES   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [2:0]  req_op,
   output logic [11:0] req_acc,
   output logic [3:0]  req_pin,
   output logic [31:0] req_amount,
   input  logic        rsp_valid,
   input  logic        rsp_error,
   input  logic [15:0] rsp_balance,
   output logic [15:0] disp_balance,
   output logic        logged_in,
   output logic        err_pulse,
   output logic        busy,
   output logic        locked
);
   localparam logic [2:0] OP_AUTH = 3'b000, OP_BAL = 3'b011, OP_WDR = 3'b100, OP_DEP = 3'b101, OP_EXIT = 3'b110;
   localparam logic [3:0] K_ENT = 4'hA, K_CLR = 4'hB, K_CAN = 4'hC;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int FW = $clog2(MAX_TRIES + 1);
   localparam int CW = $clog2(AMT_DIGITS + 1);

   typedef enum logic [2:0] {IDLE, ACC, PIN, MENU, AMT, REQ, WAIT
`ifdef ATM_LOCKOUT_EN
      , LOCKED
`endif
   } state_t;

   state_t        state, state_nxt;
   logic [11:0]   acc, acc_nxt;
   logic          acc_has, acc_has_nxt, pin_has, pin_has_nxt;
   logic [3:0]    pin, pin_nxt;
   logic [15:0]   amt, amt_nxt, disp_nxt;
   logic [CW-1:0] amt_cnt, amt_cnt_nxt;
   logic [2:0]    op, op_nxt;
   logic          logged_nxt, err_nxt;
   logic [FW-1:0] fail_cnt, fail_nxt;
   logic [TW-1:0] tmo_cnt;
   logic [16:0]   acc_mul;
   logic [19:0]   amt_mul;
   logic          is_dig, entry, key_act, tmo_hit;

   assign acc_mul = 17'(acc) * 17'd10 + 17'(key_code);
   assign amt_mul = 20'(amt) * 20'd10 + 20'(key_code);
   assign is_dig  = key_code <= 4'd9;
   assign entry   = state inside {ACC, PIN, MENU, AMT};
   assign key_act = key_valid && key_code <= K_CAN && (entry || state == IDLE);
   assign tmo_hit = entry && !key_act && tmo_cnt == TW'(TIMEOUT_CYC - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // A key pressed in the timeout cycle takes priority over the timeout.
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      acc_has_nxt = acc_has;
      pin_nxt     = pin;
      pin_has_nxt = pin_has;
      amt_nxt     = amt;
      amt_cnt_nxt = amt_cnt;
      op_nxt      = op;
      logged_nxt  = logged_in;
      disp_nxt    = disp_balance;
      fail_nxt    = fail_cnt;
      err_nxt     = 1'b0;
      if (key_act) begin
         case (state)
            IDLE: if (is_dig) begin
               state_nxt   = ACC;
               acc_nxt     = 12'(key_code);
               acc_has_nxt = 1'b1;
               pin_nxt     = '0;
               pin_has_nxt = 1'b0;
            end
            ACC:
               if (is_dig) begin
                  if (acc_mul > 17'd4095) err_nxt = 1'b1;
                  else begin
                     acc_nxt     = acc_mul[11:0];
                     acc_has_nxt = 1'b1;
                  end
               end else if (key_code == K_ENT) begin
                  if (acc_has) state_nxt = PIN;
                  else err_nxt = 1'b1;
               end else if (key_code == K_CLR) begin
                  acc_nxt     = '0;
                  acc_has_nxt = 1'b0;
               end else begin
                  state_nxt   = IDLE;
                  acc_nxt     = '0;
                  acc_has_nxt = 1'b0;
               end
            PIN:
               if (is_dig) begin
                  pin_nxt     = key_code;
                  pin_has_nxt = 1'b1;
               end else if (key_code == K_ENT) begin
                  if (pin_has) begin
                     state_nxt = REQ;
                     op_nxt    = OP_AUTH;
                  end else err_nxt = 1'b1;
               end else if (key_code == K_CLR) begin
                  pin_nxt     = '0;
                  pin_has_nxt = 1'b0;
               end else begin
                  state_nxt   = IDLE;
                  acc_nxt     = '0;
                  acc_has_nxt = 1'b0;
                  pin_nxt     = '0;
                  pin_has_nxt = 1'b0;
               end
            MENU:
               if (key_code == 4'd3 || key_code == 4'd6 || key_code == K_CAN) begin
                  state_nxt = REQ;
                  op_nxt    = key_code == 4'd3 ? OP_BAL : OP_EXIT;
               end else if (key_code == 4'd4 || key_code == 4'd5) begin
                  state_nxt   = AMT;
                  op_nxt      = key_code == 4'd4 ? OP_WDR : OP_DEP;
                  amt_nxt     = '0;
                  amt_cnt_nxt = '0;
               end else if (key_code != K_CLR) err_nxt = 1'b1;
            AMT:
               if (is_dig) begin
                  if (amt_cnt == CW'(AMT_DIGITS) || amt_mul > 20'd65535) err_nxt = 1'b1;
                  else begin
                     amt_nxt     = amt_mul[15:0];
                     amt_cnt_nxt = amt_cnt + 1'b1;
                  end
               end else if (key_code == K_ENT) begin
                  if (amt_cnt != '0) state_nxt = REQ;
                  else err_nxt = 1'b1;
               end else if (key_code == K_CLR) begin
                  amt_nxt     = '0;
                  amt_cnt_nxt = '0;
               end else begin
                  state_nxt = REQ;
                  op_nxt    = OP_EXIT;
               end
            default: ;
         endcase
      end else if (tmo_hit) begin
         err_nxt = 1'b1;
         if (state == ACC || state == PIN) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            acc_has_nxt = 1'b0;
            pin_nxt     = '0;
            pin_has_nxt = 1'b0;
         end else begin
            state_nxt = REQ;
            op_nxt    = OP_EXIT;
         end
      end else if (state == REQ && req_ready) state_nxt = WAIT;
      else if (state == WAIT && rsp_valid) begin
         if (op == OP_EXIT) begin
            state_nxt   = IDLE;
            logged_nxt  = 1'b0;
            disp_nxt    = '0;
            acc_nxt     = '0;
            acc_has_nxt = 1'b0;
            pin_nxt     = '0;
            pin_has_nxt = 1'b0;
            amt_nxt     = '0;
            amt_cnt_nxt = '0;
         end else if (op == OP_AUTH) begin
            if (rsp_error) begin
               err_nxt     = 1'b1;
               fail_nxt    = fail_cnt == FW'(MAX_TRIES) ? fail_cnt : fail_cnt + 1'b1;
               acc_nxt     = '0;
               acc_has_nxt = 1'b0;
               pin_nxt     = '0;
               pin_has_nxt = 1'b0;
               state_nxt   = IDLE;
`ifdef ATM_LOCKOUT_EN
               if (fail_cnt == FW'(MAX_TRIES - 1)) state_nxt = LOCKED;
`endif
            end else begin
               logged_nxt = 1'b1;
               fail_nxt   = '0;
               state_nxt  = MENU;
            end
         end else begin
            state_nxt = MENU;
            if (rsp_error) err_nxt = 1'b1;
            else disp_nxt = rsp_balance;
         end
      end
   end

   always_comb begin
      req_valid = state == REQ;
      busy      = state == REQ || state == WAIT;
`ifdef ATM_LOCKOUT_EN
      locked    = state == LOCKED;
`else
      locked    = 1'b0;
`endif
   end

   assign req_op     = op;
   assign req_acc    = acc;
   assign req_pin    = pin;
   assign req_amount = {16'd0, amt};

   // Timeout counter saturates rather than wrapping.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc          <= '0;
         acc_has      <= 1'b0;
         pin          <= '0;
         pin_has      <= 1'b0;
         amt          <= '0;
         amt_cnt      <= '0;
         op           <= '0;
         logged_in    <= 1'b0;
         disp_balance <= '0;
         err_pulse    <= 1'b0;
         fail_cnt     <= '0;
         tmo_cnt      <= '0;
      end else begin
         acc          <= acc_nxt;
         acc_has      <= acc_has_nxt;
         pin          <= pin_nxt;
         pin_has      <= pin_has_nxt;
         amt          <= amt_nxt;
         amt_cnt      <= amt_cnt_nxt;
         op           <= op_nxt;
         logged_in    <= logged_nxt;
         disp_balance <= disp_nxt;
         err_pulse    <= err_nxt;
         fail_cnt     <= fail_nxt;
         tmo_cnt      <= (!entry || key_act) ? '0 : tmo_cnt == TW'(TIMEOUT_CYC - 1) ? tmo_cnt : tmo_cnt + 1'b1;
      end
endmodule
